// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - op codes, FSM states and op decode helpers for the multiply/divide unit
package mult_div_pkg;

    // Encoding matches the 2-bit op field driven by the control unit.
    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    // Bit 1 of the op code selects divide, bit 0 selects signed.
    function automatic logic op_is_div(input md_op_t op);
        logic [1:0] v;
        v = op;
        return v[1];
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        logic [1:0] v;
        v = op;
        return v[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_md_step.sv
// rtl/mult_div_unit_md_step.sv - one combinational shift-add / restoring-divide iteration
//
// Ports:
//   i_div_mode  0: multiply step, 1: divide step
//   i_hi        multiply: upper product half;  divide: partial remainder
//   i_lo        multiply: lower product half holding unconsumed multiplier bits;
//               divide: dividend bits still to shift in / quotient bits shifted out
//   i_operand   multiply: multiplicand;  divide: divisor
//   o_hi, o_lo  accumulator pair after this iteration
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div_mode,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, i_operand};
        // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
        // and bit WIDTH of the difference is a clean "trial went negative" flag.
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_operand};
        o_hi    = i_hi;
        o_lo    = i_lo;
        if (i_div_mode) begin
            if (!w_diff[WIDTH]) begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // The add carry becomes the new top bit as the product shifts right.
            if (i_lo[0]) begin
                o_hi = w_sum[WIDTH:1];
                o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
            end else begin
                o_hi = {1'b0, i_hi[WIDTH-1:1]};
                o_lo = {i_hi[0], i_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle mult/multu/div/divu unit with HI/LO registers
//
// Ports:
//   clock, reset_l   rising-edge clock, asynchronous active-low reset
//   start, op        one-cycle request and op code (00 multu, 01 mult, 10 divu, 11 div)
//   a, b             rs / rt operands, captured on the accepted start
//   wr_hi, wr_lo     mthi / mtlo strobes with data on wdata, honoured only when idle
//   busy             high while calculating and fixing up
//   done             one-cycle completion pulse
//   div_zero         divide by zero flag, raised with done
//   hi, lo           HI / LO registers
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        r_state;
    md_state_t        w_next;
    md_op_t           r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    md_op_t             w_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_op    = md_op_t'(op);
    assign w_a_neg = op_is_signed(w_op) & a[WIDTH-1];
    assign w_b_neg = op_is_signed(w_op) & b[WIDTH-1];
    assign w_a_abs = w_a_neg ? -a : a;
    assign w_b_abs = w_b_neg ? -b : b;

    // Sign flags are only ever set for signed ops, so no op check is needed here.
    // |0x80000000| stays 0x80000000 as an unsigned magnitude, which gives the
    // wrap-around result for the most-negative / -1 divide without a trap.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;

    md_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_div_mode(op_is_div(r_op)),
        .i_hi      (r_acc_hi),
        .i_lo      (r_acc_lo),
        .i_operand (r_operand),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = (op_is_div(w_op) && (b == '0)) ? FIX : CALC;
            CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_op       <= MD_MULTU;
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            // Outputs are registered from the next state so they line up with the state.
            r_busy <= (w_next == CALC) || (w_next == FIX);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op       <= w_op;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dz       <= op_is_div(w_op) && (b == '0);
                        r_div_zero <= 1'b0;
                        r_cnt      <= '0;
                        r_acc_hi   <= '0;
                        if (op_is_div(w_op)) begin
                            r_acc_lo  <= w_a_abs;
                            r_operand <= w_b_abs;
                        end else begin
                            r_acc_lo  <= w_b_abs;
                            r_operand <= w_a_abs;
                        end
                    end else begin
                        if (wr_hi) r_hi <= wdata;
                        if (wr_lo) r_lo <= wdata;
                    end
                end
                CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + CW'(1);
                end
                FIX: begin
                    if (r_dz) begin
                        r_div_zero <= 1'b1;
                    end else if (op_is_div(r_op)) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock   = 1'b0;
    logic         reset_l = 1'b0;
    logic         start   = 1'b0;
    logic [1:0]   op      = 2'b00;
    logic [W-1:0] a       = '0;
    logic [W-1:0] b       = '0;
    logic         wr_hi   = 1'b0;
    logic         wr_lo   = 1'b0;
    logic [W-1:0] wdata   = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[11];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   busy_seen = 0;
    int   t0        = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (busy === 1'b1) busy_seen++;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb_q.push_back(e);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        busy_seen = 0;
        t0 = cyc;
        tick();
        start = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
        chk("div_zero_clear_on_start", {63'd0, div_zero}, 64'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        exp_t e;
        while (done !== 1'b1 && (cyc - t0) < 200) tick();
        if (done !== 1'b1) begin
            chk({tag, " done_timeout"}, {63'd0, done}, 64'd1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            return;
        end
        e = sb_q.pop_front();
        if (exp_lat >= 0)  chk({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat));
        if (exp_busy >= 0) chk({tag, " busy_cycles"}, 64'(busy_seen), 64'(exp_busy));
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, e.lo});
        chk({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
        tick();
        chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    // Reference model built on native 64-bit arithmetic; SV division truncates
    // toward zero and the remainder follows the dividend's sign.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] mh, output logic [W-1:0] ml);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00:   p = {32'd0, x} * {32'd0, y};
            2'b01:   p = 64'(sx * sy);
            2'b10:   p = {x % y, x / y};
            default: begin
                q = sx / sy;
                r = sx % sy;
                p = {r[31:0], q[31:0]};
            end
        endcase
        mh = p[63:32];
        ml = p[31:0];
    endfunction

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rx, ry, mh, ml;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5]  = '{2'b00, 32'd6,        32'd7,        32'd0,        32'd42};
        vecs[6]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{2'b10, 32'd5,        32'd9,        32'd5,        32'd0};
        vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

        // Reset state
        tick();
        tick();
        chk("reset busy",     {63'd0, busy},     64'd0);
        chk("reset done",     {63'd0, done},     64'd0);
        chk("reset div_zero", {63'd0, div_zero}, 64'd0);
        chk("reset hi",       {32'd0, hi},       64'd0);
        chk("reset lo",       {32'd0, lo},       64'd0);
        #2 reset_l = 1'b1;
        tick();

        // Directed vector table: done is high 34 edges after the start edge, busy for 33 samples
        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);
            wait_done($sformatf("vec%0d", i), W + 2, W + 1);
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            ro = 2'(i % 4);
            rx = $urandom;
            ry = $urandom;
            if (ro[1] && ry == '0) ry = 32'd1;
            model(ro, rx, ry, mh, ml);
            launch(ro, rx, ry, mh, ml, 1'b0);
            wait_done($sformatf("rand%0d", i), W + 2, W + 1);
        end

        // Divide by zero leaves HI/LO alone and finishes two edges after start
        wr_hi = 1'b1;
        wdata = 32'h11;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b1;
        wdata = 32'h22;
        tick();
        wr_lo = 1'b0;
        chk("mthi idle", {32'd0, hi}, 64'h11);
        chk("mtlo idle", {32'd0, lo}, 64'h22);
        launch(2'b10, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1);
        wait_done("divzero", 2, 1);
        launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        wait_done("after_divzero", W + 2, W + 1);

        // start and mtlo during CALC are ignored
        launch(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        repeat (5) tick();
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd99;
        b     = 32'd3;
        wr_lo = 1'b1;
        wdata = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        wr_lo = 1'b0;
        chk("midcalc still busy", {63'd0, busy}, 64'd1);
        wait_done("midcalc", W + 2, W + 1);

        // Simultaneous idle writes, then a write dropped in favour of start
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hCAFEBABE;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("both writes hi", {32'd0, hi}, 64'hCAFEBABE);
        chk("both writes lo", {32'd0, lo}, 64'hCAFEBABE);
        wr_hi = 1'b1;
        wdata = 32'h12345678;
        launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        wr_hi = 1'b0;
        wait_done("wr_with_start", W + 2, W + 1);

        // Asynchronous reset in the middle of CALC
        launch(2'b00, 32'hFFFFFFFF, 32'd3, 32'd2, 32'hFFFFFFFD, 1'b0);
        repeat (10) tick();
        #2 reset_l = 1'b0;
        #1;
        chk("async reset busy",     {63'd0, busy},     64'd0);
        chk("async reset done",     {63'd0, done},     64'd0);
        chk("async reset div_zero", {63'd0, div_zero}, 64'd0);
        chk("async reset hi",       {32'd0, hi},       64'd0);
        chk("async reset lo",       {32'd0, lo},       64'd0);
        sb_q.delete();
        tick();
        #2 reset_l = 1'b1;
        tick();
        chk("idle after reset busy", {63'd0, busy}, 64'd0);
        launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        wait_done("post_reset", W + 2, W + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
